store_buffer: RTL and testbench

Posted-write buffer between the pipelined core's data-memory port and the data memory. It accepts word stores from the core's Memory stage in one cycle and drains them in order to a slower memory through a ready handshake. While a store is pending, it forwards the youngest buffered data to loads that hit the same word. It stalls the core only when it is full.

---
 rtl/sb_pkg.sv | 16 +
 rtl/sb_fifo.sv | 54 +++++
 rtl/store_buffer.sv | 78 +++++++
 tb/tb_store_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared defaults, entry type and pointer sizing for the store buffer
package sb_pkg;

    localparam int SB_XLEN  = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [SB_XLEN-3:0] adr;
        logic [SB_XLEN-1:0] data;
    } sb_entry_t;

    function automatic int ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo: circular entry store with head/tail pointers and occupancy count
module sb_fifo
    import sb_pkg::*;
#(
    parameter type T     = sb_entry_t,
    parameter int  DEPTH = SB_DEPTH,
    parameter int  PW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  T              wr,
    output T              rd,
    output T              entries [DEPTH],
    output logic [PW-1:0] head,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd      = entries[head];

    // Pointers wrap naturally; a push and pop together leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop) head <= head + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Entry storage, cleared on reset so the memory-side outputs read zero
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (do_push) begin
            entries[tail] <= wr;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer with in-order drain and youngest-match load forwarding
module store_buffer
    import sb_pkg::*;
#(
    parameter int XLEN  = SB_XLEN,
    parameter int DEPTH = SB_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemWrite,
    input  logic [XLEN-1:0] DataAdr,
    input  logic [XLEN-1:0] WriteData,
    input  logic            MemRead,
    output logic            Stall,
    output logic            FwdHit,
    output logic [XLEN-1:0] FwdData,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready
);

    localparam int PW = ptr_w(DEPTH);

    typedef struct packed {
        logic [XLEN-3:0] adr;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          wr;
    entry_t          head_e;
    entry_t          entries [DEPTH];
    logic [PW-1:0]   head;
    logic [PW:0]     count;
    logic            full;
    logic            empty;
    logic            hit;
    logic [XLEN-1:0] hit_data;
    logic            byte_sel_unused;

    assign wr              = '{adr: DataAdr[XLEN-1:2], data: WriteData};
    assign byte_sel_unused = ^DataAdr[1:0];

    sb_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (MemWrite),
        .pop     (mem_ready),
        .wr      (wr),
        .rd      (head_e),
        .entries (entries),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign Stall     = full;
    assign mem_we    = !empty;
    assign mem_adr   = {head_e.adr, 2'b00};
    assign mem_wdata = head_e.data;

    // Walk valid entries oldest to youngest so the last match is the youngest
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PW+1)'(k) < count && entries[head + PW'(k)].adr == DataAdr[XLEN-1:2]) begin
                hit      = 1'b1;
                hit_data = entries[head + PW'(k)].data;
            end
        end
    end

    assign FwdHit  = MemRead && hit;
    assign FwdData = FwdHit ? hit_data : '0;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scoreboard bench for the store buffer
module tb_store_buffer;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            MemWrite = 1'b0;
    logic            MemRead = 1'b0;
    logic            mem_ready = 1'b0;
    logic [XLEN-1:0] DataAdr = '0;
    logic [XLEN-1:0] WriteData = '0;
    logic            Stall;
    logic            FwdHit;
    logic            mem_we;
    logic [XLEN-1:0] FwdData;
    logic [XLEN-1:0] mem_adr;
    logic [XLEN-1:0] mem_wdata;

    logic [31:0] q_adr [$];
    logic [31:0] q_data [$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          pops = 0;
    int          p0;
    logic        took;

    always #10 clk = ~clk;

    store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .Stall     (Stall),
        .FwdHit    (FwdHit),
        .FwdData   (FwdData),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Check the memory side against the model, update the model, then advance one clock
    task automatic tick();
        logic mfull;
        #1;
        took = 1'b0;
        if (reset) begin
            q_adr.delete();
            q_data.delete();
        end else begin
            mfull = q_adr.size() == DEPTH;
            chk("stall", Stall, mfull);
            chk("mem_we", mem_we, q_adr.size() != 0);
            if (q_adr.size() != 0) begin
                chk("mem_adr", mem_adr, q_adr[0]);
                chk("mem_wdata", mem_wdata, q_data[0]);
                if (mem_ready) begin
                    void'(q_adr.pop_front());
                    void'(q_data.pop_front());
                    pops++;
                end
            end
            if (MemWrite && !mfull) begin
                q_adr.push_back(DataAdr & 32'hFFFF_FFFC);
                q_data.push_back(WriteData);
                took = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        took      = 1'b0;
        for (int k = 0; k < 12 && !took; k++) tick();
        MemWrite = 1'b0;
        chk("store_taken", took, 1);
    endtask

    task automatic drain();
        mem_ready = 1'b1;
        for (int k = 0; k < 40 && q_adr.size() != 0; k++) tick();
        chk("drain_empty", q_adr.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset values
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_fwdhit", FwdHit, 0);
        chk("rst_fwddata", FwdData, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // single store, one-cycle latency to memory
        mem_ready = 1'b1;
        store(100, 7);
        chk("single_we", mem_we, 1);
        chk("single_adr", mem_adr, 100);
        chk("single_data", mem_wdata, 7);
        tick();
        chk("single_done", mem_we, 0);

        // fill to full, fifth store refused, ordered drain
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'h10 + 4 * i, i + 1);
        MemWrite  = 1'b1;
        DataAdr   = 32'h20;
        WriteData = 5;
        #1;
        chk("full_stall", Stall, 1);
        tick();
        MemWrite  = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("stall_clear", Stall, 0);
        drain();
        chk("full_drained", mem_we, 0);

        // forwarding of the youngest duplicate
        mem_ready = 1'b0;
        store(96, 32'hA);
        store(96, 32'hB);
        MemRead = 1'b1;
        DataAdr = 96;
        #1;
        chk("fwd96_hit", FwdHit, 1);
        chk("fwd96_data", FwdData, 32'hB);
        DataAdr = 98;
        #1;
        chk("fwd98_hit", FwdHit, 1);
        chk("fwd98_data", FwdData, 32'hB);
        DataAdr = 104;
        #1;
        chk("fwd104_hit", FwdHit, 0);
        chk("fwd104_data", FwdData, 0);
        MemRead = 1'b0;
        DataAdr = 96;
        #1;
        chk("noread_hit", FwdHit, 0);
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        WriteData = 32'hC;
        #1;
        chk("samecyc_data", FwdData, 32'hB);
        tick();
        MemWrite = 1'b0;
        #1;
        chk("after_push_data", FwdData, 32'hC);
        MemRead = 1'b0;
        drain();

        // full buffer with held store and continuous drain
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'h200 + 4 * i, 32'h21 + i);
        MemWrite  = 1'b1;
        DataAdr   = 32'h300;
        WriteData = 32'h25;
        mem_ready = 1'b1;
        took      = 1'b0;
        for (int k = 0; k < 8 && !took; k++) tick();
        MemWrite = 1'b0;
        chk("held_taken", took, 1);
        drain();

        // pointer wrap with alternating memory readiness
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            mem_ready = (i % 2) == 1;
            store(32'h400 + 4 * i, 32'h100 + i);
        end
        drain();
        chk("wrap_count", pops - p0, 10);

        // reset with entries pending
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h500 + 4 * i, 32'h50 + i);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_stall", Stall, 0);
        MemRead = 1'b1;
        DataAdr = 32'h504;
        #1;
        chk("rstmid_hit", FwdHit, 0);
        chk("rstmid_data", FwdData, 0);
        MemRead   = 1'b0;
        mem_ready = 1'b1;
        store(32'h600, 9);
        tick();
        chk("post_rst_done", mem_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
